udp_rx_frame_buffer: RTL and testbench

Frame-aware payload buffer placed directly downstream of the GMII UDP receive parser. It accepts the parser's 32-bit payload words and start-of-frame strobe, stores each UDP payload in a circular word RAM, and commits a frame only once every expected word has arrived. It then streams committed frames to the mmWave processing chain over a valid/ready interface with per-frame byte length and last-word marking. Partial frames and frames that would overflow the buffer are discarded whole.

---
 rtl/udp_rx_frame_buffer.sv | 225 ++++++++++++++++++++++
 tb/tb_udp_rx_frame_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_frame_buffer.sv
// udp_rx_frame_buffer: commits whole UDP payloads into a circular word RAM and streams them out with length/last.
// Define UDP_RX_BUF_STATS_EN to add saturating stat_frames/stat_drops/stat_aborts counters.
module udp_rx_frame_buffer #(
    parameter int ADDR_W      = 9,
    parameter int LEN_DEPTH_W = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        s_frame_start,
    input  logic [15:0] s_udp_len,
    input  logic [31:0] s_data,
    input  logic        s_data_valid,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] m_bytes,
    output logic        frame_pending
`ifdef UDP_RX_BUF_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_drops,
    output logic [15:0] stat_aborts
`endif
);
    localparam int PW = ADDR_W + 1;
    localparam int LW = LEN_DEPTH_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LDEPTH = 1 << LEN_DEPTH_W;
    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} r_state_t;
    logic [31:0] mem [DEPTH];
    logic [15:0] len_mem [LDEPTH];
    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_tmp_q, wr_tmp_d, rd_ptr_q, rd_ptr_d, rd_rel_q, rd_rel_d;
    logic [15:0] w_words_q, w_words_d, w_cnt_q, w_cnt_d, w_bytes_q, w_bytes_d, r_left_q, r_left_d;
    logic [LW-1:0] lf_wp_q, lf_wp_d, lf_rp_q, lf_rp_d;
    logic [31:0] skid_q, skid_d, m_data_q, m_data_d;
    logic skid_v_q, skid_v_d, skid_last_q, skid_last_d;
    logic m_valid_q, m_valid_d, m_last_q, m_last_d, frame_pending_q, frame_pending_d;
    logic [15:0] m_bytes_q, m_bytes_d;
    logic [LW:0] pend_q, pend_d;
    logic [15:0] p, w, words, commit_bytes, r_p, r_w, left_eff;
    logic [PW-1:0] free;
    logic [31:0] rd_word;
    logic first, mem_we, commit, drop_evt, abort_evt, lf_full, lf_empty;
    logic out_free, hs_last, rd_en, rd_last;

    assign p = s_udp_len - 16'd8;
    assign w = (p + 16'd3) >> 2;
    assign free = PW'(DEPTH) - (wr_ptr_q - rd_rel_q);
    assign lf_full = (lf_wp_q - lf_rp_q) == LW'(LDEPTH);
    assign lf_empty = lf_wp_q == lf_rp_q;
    assign first = w_cnt_q == 16'd0;
    assign words = first ? w : w_words_q;
    assign commit_bytes = first ? p : w_bytes_q;

    always_comb begin
        w_state_d = w_state_q;
        wr_ptr_d  = wr_ptr_q;
        wr_tmp_d  = wr_tmp_q;
        w_words_d = w_words_q;
        w_cnt_d   = w_cnt_q;
        w_bytes_d = w_bytes_q;
        mem_we    = 1'b0;
        commit    = 1'b0;
        drop_evt  = 1'b0;
        abort_evt = 1'b0;
        if (s_frame_start) begin
            abort_evt = w_state_q == W_RECV;
            w_state_d = W_RECV;
            wr_tmp_d  = wr_ptr_q;
            w_cnt_d   = 16'd0;
        end else if (s_data_valid && w_state_q == W_RECV) begin
            if (first && (s_udp_len < 16'd9 || 32'(w) > 32'(free) || lf_full || 32'(w) > 32'(DEPTH))) begin
                w_state_d = W_DROP;
                drop_evt  = 1'b1;
            end else begin
                mem_we    = 1'b1;
                wr_tmp_d  = wr_tmp_q + PW'(1);
                w_cnt_d   = w_cnt_q + 16'd1;
                w_words_d = words;
                w_bytes_d = commit_bytes;
                if (w_cnt_q + 16'd1 == words) begin
                    commit    = 1'b1;
                    wr_ptr_d  = wr_tmp_q + PW'(1);
                    w_state_d = W_IDLE;
                end
            end
        end
    end

    // Reads go straight into the output register when it is free, otherwise into the skid register.
    assign r_p = len_mem[lf_rp_q[LEN_DEPTH_W-1:0]];
    assign r_w = (r_p + 16'd3) >> 2;
    assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
    assign out_free = !m_valid_q || m_ready;
    assign hs_last = m_valid_q && m_ready && m_last_q;
    assign left_eff = r_state_q == R_LOAD ? r_w : (r_state_q == R_DATA ? r_left_q : 16'd0);
    assign rd_en = left_eff != 16'd0 && (!skid_v_q || out_free);
    assign rd_last = left_eff == 16'd1;

    always_comb begin
        r_state_d   = r_state_q;
        rd_ptr_d    = rd_ptr_q + PW'(rd_en);
        rd_rel_d    = rd_rel_q;
        r_left_d    = r_state_q == R_IDLE ? r_left_q : left_eff - 16'(rd_en);
        lf_wp_d     = lf_wp_q + LW'(commit);
        lf_rp_d     = lf_rp_q;
        skid_d      = skid_q;
        skid_v_d    = skid_v_q;
        skid_last_d = skid_last_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_bytes_d   = m_bytes_q;
        if (out_free) begin
            m_valid_d = skid_v_q || rd_en;
            m_data_d  = skid_v_q ? skid_q : (rd_en ? rd_word : m_data_q);
            m_last_d  = skid_v_q ? skid_last_q : rd_en && rd_last;
        end
        if (rd_en && (skid_v_q || !out_free)) begin
            skid_d      = rd_word;
            skid_last_d = rd_last;
            skid_v_d    = 1'b1;
        end else if (out_free) begin
            skid_v_d = 1'b0;
        end
        if (r_state_q == R_IDLE && !lf_empty) r_state_d = R_LOAD;
        if (r_state_q == R_LOAD) begin
            lf_rp_d   = lf_rp_q + LW'(1);
            m_bytes_d = r_p;
            r_state_d = R_DATA;
        end
        if (r_state_q == R_DATA && hs_last) begin
            rd_rel_d  = rd_ptr_q;
            r_state_d = R_IDLE;
        end
        pend_d = pend_q + (LW+1)'(commit) - (LW+1)'(hs_last);
        frame_pending_d = pend_d != '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_tmp_q[ADDR_W-1:0]] <= s_data;
        if (commit) len_mem[lf_wp_q[LEN_DEPTH_W-1:0]] <= commit_bytes;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wr_ptr_q <= '0;
            wr_tmp_q <= '0;
            rd_ptr_q <= '0;
            rd_rel_q <= '0;
            w_words_q <= '0;
            w_cnt_q <= '0;
            w_bytes_q <= '0;
            r_left_q <= '0;
            lf_wp_q <= '0;
            lf_rp_q <= '0;
            skid_q <= '0;
            skid_v_q <= 1'b0;
            skid_last_q <= 1'b0;
            m_data_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q <= 1'b0;
            m_bytes_q <= '0;
            pend_q <= '0;
            frame_pending_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wr_ptr_q <= wr_ptr_d;
            wr_tmp_q <= wr_tmp_d;
            rd_ptr_q <= rd_ptr_d;
            rd_rel_q <= rd_rel_d;
            w_words_q <= w_words_d;
            w_cnt_q <= w_cnt_d;
            w_bytes_q <= w_bytes_d;
            r_left_q <= r_left_d;
            lf_wp_q <= lf_wp_d;
            lf_rp_q <= lf_rp_d;
            skid_q <= skid_d;
            skid_v_q <= skid_v_d;
            skid_last_q <= skid_last_d;
            m_data_q <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q <= m_last_d;
            m_bytes_q <= m_bytes_d;
            pend_q <= pend_d;
            frame_pending_q <= frame_pending_d;
        end
    end

    assign m_data = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last = m_last_q;
    assign m_bytes = m_bytes_q;
    assign frame_pending = frame_pending_q;

`ifdef UDP_RX_BUF_STATS_EN
    logic [15:0] stat_frames_q, stat_frames_d, stat_drops_q, stat_drops_d, stat_aborts_q, stat_aborts_d;
    always_comb begin
        stat_frames_d = stat_frames_q + 16'(commit && stat_frames_q != '1);
        stat_drops_d  = stat_drops_q + 16'(drop_evt && stat_drops_q != '1);
        stat_aborts_d = stat_aborts_q + 16'(abort_evt && stat_aborts_q != '1);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            stat_frames_q <= '0;
            stat_drops_q <= '0;
            stat_aborts_q <= '0;
        end else begin
            stat_frames_q <= stat_frames_d;
            stat_drops_q <= stat_drops_d;
            stat_aborts_q <= stat_aborts_d;
        end
    end
    assign stat_frames = stat_frames_q;
    assign stat_drops = stat_drops_q;
    assign stat_aborts = stat_aborts_q;
`endif
endmodule

// File: tb/tb_udp_rx_frame_buffer.sv
// tb_udp_rx_frame_buffer: scoreboard bench for udp_rx_frame_buffer with a 16-word RAM.
// Stats ports are checked only when UDP_RX_BUF_STATS_EN is defined.
module tb_udp_rx_frame_buffer;
    logic clk = 1'b0, clr = 1'b1, s_frame_start = 1'b0, s_data_valid = 1'b0, m_ready = 1'b0;
    logic [15:0] s_udp_len = '0;
    logic [31:0] s_data = '0;
    logic [31:0] m_data;
    logic m_valid, m_last, frame_pending;
    logic [15:0] m_bytes;
    int n_cmp = 0, n_bad = 0, rdy_mode = 0;
    logic [48:0] sb [$];
`ifdef UDP_RX_BUF_STATS_EN
    logic [15:0] stat_frames, stat_drops, stat_aborts;
`endif

    udp_rx_frame_buffer #(.ADDR_W(4), .LEN_DEPTH_W(2)) dut (
        .clk(clk), .clr(clr), .s_frame_start(s_frame_start), .s_udp_len(s_udp_len),
        .s_data(s_data), .s_data_valid(s_data_valid), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .m_bytes(m_bytes), .frame_pending(frame_pending)
`ifdef UDP_RX_BUF_STATS_EN
        , .stat_frames(stat_frames), .stat_drops(stat_drops), .stat_aborts(stat_aborts)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode == 1;
        end
    end

    // Monitor: every output handshake pops one expected {data, last, bytes}.
    always @(negedge clk) begin
        if (!clr && m_valid && m_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got data=%h last=%b bytes=%0d, required none", m_data, m_last, m_bytes);
            end else begin
                logic [48:0] e;
                e = sb.pop_front();
                if ({m_data, m_last, m_bytes} !== e) begin
                    n_bad++;
                    $display("FAIL word: got data=%h last=%b bytes=%0d, required data=%h last=%b bytes=%0d",
                             m_data, m_last, m_bytes, e[48:17], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] len, input int n, input logic [31:0] base, input bit push);
        logic [15:0] p, wn;
        logic [31:0] d;
        p = len - 16'd8;
        wn = (p + 16'd3) >> 2;
        s_frame_start = 1'b1;
        tick();
        s_frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = base + 32'(i) * 32'h01010101;
            if (i == int'(wn) - 1 && p[1:0] != 2'd0) d &= ~(32'hFFFFFFFF >> (8 * p[1:0]));
            s_udp_len = len;
            s_data = d;
            s_data_valid = 1'b1;
            if (push) sb.push_back({d, i == n - 1, p});
            tick();
        end
        s_data_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb.size() != 0 || m_valid) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d words outstanding, required 0", name, sb.size());
        end
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_bytes", 32'(m_bytes), 32'd0);
        chk("rst_frame_pending", 32'(frame_pending), 32'd0);
        clr = 1'b0;
        rdy_mode = 1;
        tick();
        // 20-byte UDP length: 12 payload bytes in 3 words
        send(16'd20, 3, 32'h11223344, 1'b1);
        tick();
        chk("pending_after_commit", 32'(frame_pending), 32'd1);
        drain("single");
        tick();
        chk("pending_cleared", 32'(frame_pending), 32'd0);
        // P=5: second word keeps one byte, low 24 bits padded
        send(16'd13, 2, 32'hA1A2A3A4, 1'b1);
        drain("pad");
        // abort an 8-word frame after 4 words, then a clean 3-word frame
        send(16'd40, 4, 32'hDEAD0000, 1'b0);
        send(16'd20, 3, 32'h55667788, 1'b1);
        drain("abort");
`ifdef UDP_RX_BUF_STATS_EN
        chk("stat_aborts", 32'(stat_aborts), 32'd1);
`endif
        // overflow: 12 words held, 6-word frame does not fit in the 4 free words
        rdy_mode = 0;
        tick();
        send(16'd56, 12, 32'h0A000000, 1'b1);
        send(16'd32, 6, 32'h0B000000, 1'b0);
        repeat (5) tick();
        chk("ovf_valid_held", 32'(m_valid), 32'd1);
        chk("ovf_pending", 32'(frame_pending), 32'd1);
        chk("ovf_bytes", 32'(m_bytes), 32'd48);
        rdy_mode = 1;
        drain("overflow");
`ifdef UDP_RX_BUF_STATS_EN
        chk("stat_drops", 32'(stat_drops), 32'd1);
        chk("stat_frames", 32'(stat_frames), 32'd4);
`endif
        // five 7-word frames under random backpressure, wrapping the 16-word RAM
        rdy_mode = 2;
        for (int f = 0; f < 5; f++) begin
            int k;
            k = 0;
            while (sb.size() > 7 && k < 400) begin
                tick();
                k++;
            end
            send(16'd36, 7, 32'h10000000 * (f + 1), 1'b1);
        end
        drain("wrap");
        rdy_mode = 1;
        tick();
        chk("wrap_pending", 32'(frame_pending), 32'd0);
        // clear while a frame is being presented
        rdy_mode = 0;
        tick();
        send(16'd36, 7, 32'h77000000, 1'b0);
        repeat (4) tick();
        chk("pre_clr_valid", 32'(m_valid), 32'd1);
        clr = 1'b1;
        tick();
        @(negedge clk);
        chk("clr_m_valid", 32'(m_valid), 32'd0);
        chk("clr_pending", 32'(frame_pending), 32'd0);
        clr = 1'b0;
        tick();
        rdy_mode = 1;
        send(16'd20, 3, 32'hC0C1C2C3, 1'b1);
        drain("post_clr");
        tick();
        chk("post_clr_pending", 32'(frame_pending), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
